// File: rtl/barrel_shift_left_pipe_pkg.sv
// Shared shift-path definitions: datapath width, shift-amount width and the
// shift op encoding used by both barrel shifters and the ALU decoder.
package barrel_shift_left_pipe_pkg;

   localparam int WIDTH = 32;
   localparam int SHW   = 5;

   typedef enum logic {
      SHIFT_LSL = 1'b0,
      SHIFT_ROL = 1'b1
   } shift_op_e;

endpackage

// File: rtl/barrel_shift_left_pipe_stage.sv
// One level of the left barrel shifter: conditional shift/rotate by AMT,
// followed by the stage register and its share of the ready chain.
module shift_left_stage
   import barrel_shift_left_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT   = 1,
   parameter int SHW   = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_vld,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_rot,
   input  logic [SHW-1:0]   i_shamt,
   input  logic             i_adv_next,
   output logic             o_adv,
   output logic             o_vld,
   output logic [WIDTH-1:0] o_data,
   output logic             o_rot,
   output logic [SHW-1:0]   o_shamt
);

   localparam int BIT = $clog2(AMT);

   logic             r_vld;
   logic [WIDTH-1:0] r_data;
   logic             r_rot;
   logic [SHW-1:0]   r_shamt;
   logic [WIDTH-1:0] w_shifted;

   function automatic logic [WIDTH-1:0] shift_mux(input logic [WIDTH-1:0] d,
                                                  input logic en,
                                                  input logic r);
      if (!en)
         return d;
      if (shift_op_e'(r) == SHIFT_ROL)
         return (d << AMT) | (d >> (WIDTH - AMT));
      return d << AMT;
   endfunction

   assign w_shifted = shift_mux(i_data, i_shamt[BIT], i_rot);

   // A stage may take a new entry when it is empty or its contents move on.
   assign o_adv = ~r_vld | i_adv_next;

   // Stage register: data only loads with a valid entry so the final stage
   // keeps its last result visible through bubbles.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_vld   <= 1'b0;
         r_data  <= '0;
         r_rot   <= 1'b0;
         r_shamt <= '0;
      end else if (o_adv) begin
         r_vld <= i_vld;
         if (i_vld) begin
            r_data  <= w_shifted;
            r_rot   <= i_rot;
            r_shamt <= i_shamt;
         end
      end
   end

   assign o_vld   = r_vld;
   assign o_data  = r_data;
   assign o_rot   = r_rot;
   assign o_shamt = r_shamt;

endmodule

// File: rtl/barrel_shift_left_pipe.sv
// Pipelined left shift / rotate: one shift-amount bit resolved per stage,
// MSB first, with a collapsing valid/ready pipeline.
module barrel_shift_left_pipe
   import barrel_shift_left_pipe_pkg::*;
#(
   parameter int WIDTH = barrel_shift_left_pipe_pkg::WIDTH,
   parameter int SHW   = barrel_shift_left_pipe_pkg::SHW
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   shamt,
   input  logic             rot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s
);

   logic             w_vld   [0:SHW];
   logic [WIDTH-1:0] w_data  [0:SHW];
   logic             w_rot   [0:SHW];
   logic [SHW-1:0]   w_shamt [0:SHW];
   logic             w_adv   [0:SHW];
   logic             w_unused_tail;

   assign w_vld[0]   = in_valid;
   assign w_data[0]  = a;
   assign w_rot[0]   = rot;
   assign w_shamt[0] = shamt;
   assign w_adv[SHW] = out_ready;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      shift_left_stage #(
         .WIDTH (WIDTH),
         .AMT   (1 << (SHW - 1 - k)),
         .SHW   (SHW)
      ) u_stage (
         .clock      (clock),
         .reset      (reset),
         .i_vld      (w_vld[k]),
         .i_data     (w_data[k]),
         .i_rot      (w_rot[k]),
         .i_shamt    (w_shamt[k]),
         .i_adv_next (w_adv[k+1]),
         .o_adv      (w_adv[k]),
         .o_vld      (w_vld[k+1]),
         .o_data     (w_data[k+1]),
         .o_rot      (w_rot[k+1]),
         .o_shamt    (w_shamt[k+1])
      );
   end

   // Control carried out of the last stage has no further consumer.
   assign w_unused_tail = ^{w_rot[SHW], w_shamt[SHW]};

   assign in_ready  = w_adv[0];
   assign out_valid = w_vld[SHW];
   assign s         = w_data[SHW];

endmodule

// File: tb/tb_barrel_shift_left_pipe.sv
// Bench for barrel_shift_left_pipe: directed vectors, stall/reset scenarios
// and a long random run against a queue-based reference model.
module tb_barrel_shift_left_pipe;

   localparam int W = 32;
   localparam int N = 5;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [N-1:0] shamt;
   logic         rot;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;

   int           npass = 0;
   int           ntotal = 0;
   int           ndrained = 0;
   logic         g_acc;
   logic [W-1:0] last_s;
   logic [W-1:0] q[$];

   always #5 clock = ~clock;

   barrel_shift_left_pipe dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .shamt     (shamt),
      .rot       (rot),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s)
   );

   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] av,
                                              input logic [N-1:0] sh,
                                              input logic r);
      logic [2*W-1:0] dbl;
      dbl = {av, av} << sh;
      return r ? dbl[2*W-1:W] : (av << sh);
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   // Called at posedge+1 with inputs already driven; advances one cycle.
   task automatic cyc();
      logic drn;
      #1;
      chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < N) || out_ready});
      if (out_valid) begin
         chk("out_valid_has_op", {31'b0, q.size() != 0}, 32'd1);
      end else begin
         chk("s_hold", s, last_s);
      end
      g_acc = in_valid && in_ready;
      drn   = out_valid && out_ready;
      if (drn) begin
         if (q.size() > 0) chk("s_result", s, q.pop_front());
         ndrained++;
      end
      if (out_valid) last_s = s;
      if (g_acc) q.push_back(ref_shift(a, shamt, rot));
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      q.delete();
      last_s = '0;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_s", s, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic single(input logic [W-1:0] av, input logic [N-1:0] sh,
                         input logic r, input logic [W-1:0] exp, input string tag);
      int lat;
      a = av; shamt = sh; rot = r; in_valid = 1'b1; out_ready = 1'b1;
      cyc();
      chk({tag, "_accepted"}, {31'b0, g_acc}, 32'd1);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         cyc();
         lat++;
      end
      chk({tag, "_latency"}, lat, 32'd5);
      chk(tag, s, exp);
      cyc();
      chk({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      int sent;
      int start_drained;
      int cyc_cnt;
      logic saw_stall;
      logic [W-1:0] ops_a [8];
      logic [N-1:0] ops_sh [8];
      logic         ops_r [8];

      a = '0; shamt = '0; rot = 1'b0; in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
      @(posedge clock);
      #1;
      do_reset();

      single(32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, "lsl_31");
      single(32'h8000_0001, 5'd1,  1'b1, 32'h0000_0003, "rol_1");
      single(32'h8000_0001, 5'd1,  1'b0, 32'h0000_0002, "lsl_1");
      single(32'hF0F0_0F0F, 5'd16, 1'b1, 32'h0F0F_F0F0, "rol_16");
      single(32'hF0F0_0F0F, 5'd16, 1'b0, 32'h0F0F_0000, "lsl_16");
      single(32'hF0F0_0F0F, 5'd0,  1'b0, 32'hF0F0_0F0F, "lsl_0");
      single(32'hF0F0_0F0F, 5'd0,  1'b1, 32'hF0F0_0F0F, "rol_0");

      // Back-to-back stream with a four-cycle consumer stall.
      for (int i = 0; i < 8; i++) begin
         ops_a[i] = $urandom; ops_sh[i] = N'($urandom); ops_r[i] = 1'($urandom);
      end
      sent = 0; saw_stall = 1'b0; start_drained = ndrained; cyc_cnt = 0;
      while ((sent < 8 || q.size() != 0) && cyc_cnt < 40) begin
         out_ready = !(cyc_cnt >= 3 && cyc_cnt < 7);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            a = ops_a[sent]; shamt = ops_sh[sent]; rot = ops_r[sent];
         end
         #0;
         if (in_valid && !in_ready) saw_stall = 1'b1;
         cyc();
         if (g_acc) sent++;
         cyc_cnt++;
      end
      in_valid = 1'b0;
      chk("stream_count", ndrained - start_drained, 32'd8);
      chk("stream_stall_seen", {31'b0, saw_stall}, 32'd1);

      // Reset with three operations in flight.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = $urandom; shamt = N'($urandom); rot = 1'($urandom);
         cyc();
      end
      chk("pre_reset_inflight", q.size(), 32'd3);
      do_reset();
      single(32'h1234_5678, 5'd4, 1'b1, 32'h2345_6781, "post_reset_rol_4");

      // Long random run with random back-pressure.
      sent = 0; cyc_cnt = 0; start_drained = ndrained;
      while (sent < 10000 && cyc_cnt < 40000) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         a = $urandom; shamt = N'($urandom); rot = 1'($urandom);
         cyc();
         if (g_acc) sent++;
         cyc_cnt++;
      end
      chk("random_accepted", sent, 32'd10000);
      in_valid = 1'b0; out_ready = 1'b1; cyc_cnt = 0;
      while (q.size() != 0 && cyc_cnt < 20) begin
         cyc();
         cyc_cnt++;
      end
      chk("random_queue_empty", q.size(), 32'd0);
      chk("random_drained", ndrained - start_drained, 32'd10000);
      cyc();
      chk("final_idle", {31'b0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
